// File: rtl/readout_decoder_if.sv
// Bus between a requester and readout_decoder: start/bcd request and the
// registered binary result with its ready / done_tick / ovf / err status.
interface readout_decoder_if #(
  parameter int BCD_N = 3,
  parameter int BIN_N = 10
);
  logic               start;
  logic [BCD_N*4-1:0] bcd;
  logic [BIN_N-1:0]   bin;
  logic               ready;
  logic               done_tick;
  logic               ovf;
  logic               err;

  modport master (output start, bcd, input bin, ready, done_tick, ovf, err);
  modport slave  (input start, bcd, output bin, ready, done_tick, ovf, err);
endinterface

// File: rtl/readout_decoder.sv
// Serial packed-BCD to binary converter, one digit per cycle, MSD first.
// Optional invalid-digit detection under `READOUT_DECODER_DIGIT_CHECK_EN.
module readout_decoder #(
  parameter int BCD_N = 3,
  parameter int BIN_N = 10
) (
  input  logic              clk,
  input  logic              reset,
  readout_decoder_if.slave  bus
);
  localparam int CNT_W = $clog2(BCD_N + 1);
  localparam int ACC_W = BIN_N + 4;
  localparam int SR_W  = BCD_N * 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OP = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [SR_W-1:0]  r_sreg;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_N-1:0] r_bin;
  logic             r_ovf;
  logic [3:0]       w_digit;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_last;
  logic             w_bad_nxt;

  assign w_digit   = r_sreg[SR_W-1 -: 4];
  assign w_acc_nxt = r_acc * ACC_W'(10) + ACC_W'(w_digit);
  assign w_last    = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_OP;
      S_OP:    if (w_last)    w_state_nxt = S_DONE;
      S_DONE:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_sreg <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_sreg <= bus.bcd;
          r_acc  <= '0;
          r_cnt  <= CNT_W'(BCD_N);
        end
        S_OP: begin
          r_acc  <= w_acc_nxt;
          r_sreg <= r_sreg << 4;
          r_cnt  <= r_cnt - CNT_W'(1);
          // Results latch on the edge consuming the last digit, so they are
          // already valid during the done cycle and hold until the next one.
          if (w_last) begin
            r_bin <= w_bad_nxt ? '0 : w_acc_nxt[BIN_N-1:0];
            r_ovf <= !w_bad_nxt && (|w_acc_nxt[ACC_W-1:BIN_N]);
          end
        end
        default: ;
      endcase
    end

`ifdef READOUT_DECODER_DIGIT_CHECK_EN
  logic r_bad, r_err;

  // Sticky per conversion; includes the digit consumed on this edge.
  assign w_bad_nxt = r_bad | (w_digit > 4'd9);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_bad <= 1'b0;
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_bad <= 1'b0;
    end else if (r_state == S_OP) begin
      r_bad <= w_bad_nxt;
      if (w_last) r_err <= w_bad_nxt;
    end

  assign bus.err = r_err;
`else
  assign w_bad_nxt = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.bin       = r_bin;
  assign bus.ovf       = r_ovf;
  assign bus.ready     = (r_state == S_IDLE);
  assign bus.done_tick = (r_state == S_DONE);
endmodule

// File: doc/readout_decoder.md
READOUT_DECODER -- requirements
Module: readout_decoder

Interface
REQ-001 SHALL have parameter BCD_N, default 3, number of packed BCD digits converted.
REQ-002 SHALL have parameter BIN_N, default 10, width of the binary result.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request conversion, sampled only while ready=1.
REQ-006 SHALL have port bcd  input  BCD_N*4  packed digits, most significant digit in the top nibble.
REQ-007 SHALL have port bin  output  BIN_N  registered binary result.
REQ-008 SHALL have port ready  output  1  high only in idle.
REQ-009 SHALL have port done_tick  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port ovf  output  1  registered overflow flag for the last completed conversion.
REQ-011 SHALL have port err  output  1  registered invalid-digit flag for the last completed conversion.

Function
REQ-012 SHALL implement the states idle, op and done, encoded in a 2-bit register.
REQ-013 SHALL, in idle with start=1 at a rising edge, capture bcd into a shift register, clear the accumulator, load the digit counter with BCD_N and enter op.
REQ-014 SHALL, each op cycle, set acc = acc*10 + top nibble, shift the register left 4 bits and decrement the counter.
REQ-015 SHALL leave op for done on the edge that consumes the last digit, giving exactly BCD_N op cycles.
REQ-016 SHALL, in done, assert done_tick for exactly one cycle, present the updated bin, ovf and err, and return to idle on the next edge.
REQ-017 SHALL assert done_tick exactly BCD_N+1 cycles after the edge on which start was sampled.
REQ-018 SHALL ignore start outside idle; start held high re-triggers only on the first idle edge after done.
REQ-019 SHALL use an accumulator of BIN_N+4 bits; ovf=1 when the final value >= 2^BIN_N, and bin then takes the low BIN_N bits.
REQ-020 SHALL hold bin, ovf and err stable from one done state until the next done state.
REQ-021 SHALL convert bcd = 0 to bin = 0 with ovf=0 and err=0.

Reset
REQ-022 SHALL, while reset=0, force state to idle and clear bin, ovf, err, the accumulator, the shift register and the counter.
REQ-023 SHALL abandon a conversion on reset mid-operation; no done_tick SHALL follow, and ready=1 in the first cycle after release.
REQ-024 SHALL drive done_tick=0 and ready=1 during reset.

Configuration
REQ-025 SHALL honour macro READOUT_DECODER_DIGIT_CHECK_EN.
REQ-026 SHALL, with the macro defined, set an internal sticky flag when any consumed digit is greater than 9; at done, err=1 and bin=0, and ovf=0 for that conversion.
REQ-027 SHALL, without the macro, tie err to 0 and accumulate digits above 9 arithmetically (acc*10 + digit) with no special handling.

Verification
REQ-028 SHALL check: BCD_N=3, BIN_N=10, bcd=0x123, start pulse -> done_tick exactly 4 cycles later, bin=123, ovf=0, err=0.
REQ-029 SHALL check: bcd=0x999 -> bin=999, ovf=0; then bcd=0x000 -> bin=0.
REQ-030 SHALL check: BIN_N=9, bcd=0x999 -> ovf=1, bin=487.
REQ-031 SHALL check: bcd=0x1A3 -> macro defined: err=1, bin=0; macro undefined: err=0, bin=203.
REQ-032 SHALL check: start held high for 10 cycles with bcd=0x042 -> done_tick once every 5 cycles, bin=42, ready low during op and done.
REQ-033 SHALL check: reset asserted 2 cycles into a conversion of 0x555 -> no done_tick, bin=0, ready=1 in the first cycle after release.
